// File: rtl/stream_capture_reader.sv
// Captures a programmed number of 64-bit stream samples into RAM after arm and
// returns them to the host as 32-bit words (low half first). Optional: CAPTURE_READ_WRAP_EN.
module stream_capture_reader #(
    parameter int DATA_W     = 64,
    parameter int RD_W       = 32,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  arm,
    input  logic [31:0]           n_samples,
    input  logic [DATA_W-1:0]     data_in,
    input  logic                  data_in_valid,
    input  logic                  rd_req,
    output logic [RD_W-1:0]       rd_data,
    output logic                  rd_data_valid,
    output logic                  busy,
    output logic                  capture_done,
    output logic [DEPTH_LOG2:0]   samples_stored,
    output logic                  underrun,
    output logic                  rd_err
);

    localparam int                  DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [31:0]         DEPTH_32   = 32'(DEPTH);
    localparam logic [DEPTH_LOG2:0] DEPTH_V    = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] CNT_ONE    = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2:0] CNT_ZERO   = {(DEPTH_LOG2+1){1'b0}};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] PTR_ZERO = {DEPTH_LOG2{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [DATA_W-1:0]      ram_r [DEPTH];
    logic [DATA_W-1:0]      ram_q_r;
    logic [DEPTH_LOG2:0]    target_r;
    logic [DEPTH_LOG2:0]    target_s;
    logic [DEPTH_LOG2:0]    stored_r;
    logic [DEPTH_LOG2-1:0]  wr_ptr_r;
    logic [DEPTH_LOG2:0]    rd_ptr_r;
    logic [DEPTH_LOG2-1:0]  rd_addr_s;
    logic                   half_r;
    logic                   wr_en_s;
    logic                   rd_go_s;
    logic                   past_end_s;
    logic                   last_wr_s;
    logic                   s1_valid_r;
    logic                   s1_half_r;
    logic                   s1_zero_r;
    logic [RD_W-1:0]        rd_data_r;
    logic                   rd_valid_r;
    logic                   underrun_r;
    logic                   rd_err_r;
    logic                   busy_s;
    logic                   done_s;
    logic                   busy_r;
    logic                   done_r;

    // Qualified write/read strobes; arm and reset both abort any access in their cycle.
    always_comb begin
        wr_en_s    = reset_n && !arm && (state_r == ST_CAPTURE) && data_in_valid;
        rd_go_s    = reset_n && !arm && (state_r == ST_DONE) && rd_req;
        past_end_s = (rd_ptr_r >= stored_r);
        last_wr_s  = ((stored_r + CNT_ONE) == target_r);
        rd_addr_s  = rd_ptr_r[DEPTH_LOG2-1:0];
    end

    // Capture length clamped to the buffer depth.
    always_comb begin
        if (n_samples > DEPTH_32) begin
            target_s = DEPTH_V;
        end else begin
            target_s = n_samples[DEPTH_LOG2:0];
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; arm overrides every state.
    always_comb begin
        state_nxt_s = state_r;
        if (arm) begin
            if (target_s == CNT_ZERO) begin
                state_nxt_s = ST_DONE;
            end else begin
                state_nxt_s = ST_CAPTURE;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_nxt_s = ST_IDLE;
                end
                ST_CAPTURE: begin
                    if (wr_en_s && last_wr_s) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_CAPTURE;
                    end
                end
                ST_DONE: begin
                    state_nxt_s = ST_DONE;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // FSM output decode, taken from the next state so the registered flags track state_r.
    always_comb begin
        busy_s = 1'b0;
        done_s = 1'b0;
        case (state_nxt_s)
            ST_IDLE: begin
                busy_s = 1'b0;
                done_s = 1'b0;
            end
            ST_CAPTURE: begin
                busy_s = 1'b1;
                done_s = 1'b0;
            end
            ST_DONE: begin
                busy_s = 1'b0;
                done_s = 1'b1;
            end
            default: begin
                busy_s = 1'b0;
                done_s = 1'b0;
            end
        endcase
    end

    // Registered status flags.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= busy_s;
            done_r <= done_s;
        end
    end

    // Capture length, write pointer and stored-sample count.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            target_r <= CNT_ZERO;
            wr_ptr_r <= PTR_ZERO;
            stored_r <= CNT_ZERO;
        end else if (arm) begin
            target_r <= target_s;
            wr_ptr_r <= PTR_ZERO;
            stored_r <= CNT_ZERO;
        end else if (wr_en_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
            stored_r <= stored_r + CNT_ONE;
        end else begin
            wr_ptr_r <= wr_ptr_r;
            stored_r <= stored_r;
        end
    end

    // Sample buffer write port.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            ram_r[wr_ptr_r] <= data_in;
        end
    end

    // Sample buffer registered read port, left unreset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (rd_go_s) begin
            ram_q_r <= ram_r[rd_addr_s];
        end
    end

    // Read pointer and half select; past-end reads leave both untouched.
    always_ff @(posedge clk) begin
        if (!reset_n || arm) begin
            rd_ptr_r <= CNT_ZERO;
            half_r   <= 1'b0;
        end else if (rd_go_s && !past_end_s) begin
            if (half_r) begin
                half_r <= 1'b0;
`ifdef CAPTURE_READ_WRAP_EN
                if ((rd_ptr_r + CNT_ONE) == stored_r) begin
                    rd_ptr_r <= CNT_ZERO;
                end else begin
                    rd_ptr_r <= rd_ptr_r + CNT_ONE;
                end
`else
                rd_ptr_r <= rd_ptr_r + CNT_ONE;
`endif
            end else begin
                half_r <= 1'b1;
            end
        end else begin
            rd_ptr_r <= rd_ptr_r;
            half_r   <= half_r;
        end
    end

    // Read stage 1: request qualifiers travelling alongside the RAM read.
    always_ff @(posedge clk) begin
        if (!reset_n || arm) begin
            s1_valid_r <= 1'b0;
            s1_half_r  <= 1'b0;
            s1_zero_r  <= 1'b0;
        end else begin
            s1_valid_r <= rd_go_s;
            s1_half_r  <= half_r;
            s1_zero_r  <= past_end_s;
        end
    end

    // Read stage 2: half select / past-end zeroing into the output register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_data_r  <= {RD_W{1'b0}};
            rd_valid_r <= 1'b0;
            underrun_r <= 1'b0;
        end else if (arm) begin
            rd_valid_r <= 1'b0;
            underrun_r <= 1'b0;
        end else begin
            rd_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                if (s1_zero_r) begin
                    rd_data_r  <= {RD_W{1'b0}};
                    underrun_r <= 1'b1;
                end else if (s1_half_r) begin
                    rd_data_r <= ram_q_r[DATA_W-1:RD_W];
                end else begin
                    rd_data_r <= ram_q_r[RD_W-1:0];
                end
            end
        end
    end

    // Access-outside-DONE flag, one cycle after the offending request.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_err_r <= 1'b0;
        end else begin
            rd_err_r <= rd_req && (state_r != ST_DONE);
        end
    end

    // A word leaving the output register in the same cycle as arm/reset still counts
    // as in flight, so the qualifier is masked rather than delivered.
    assign rd_data_valid  = rd_valid_r & ~arm & reset_n;
    assign rd_data        = rd_data_r;
    assign busy           = busy_r;
    assign capture_done   = done_r;
    assign samples_stored = stored_r;
    assign underrun       = underrun_r;
    assign rd_err         = rd_err_r;

endmodule

// File: doc/stream_capture_reader.md
Name: stream_capture_reader

Overview:
- Host-side reader for the 64-bit processed sample stream (data_out / data_out_valid) leaving the signal-processing stage.
- Captures a programmed number of samples into on-chip RAM once armed, then lets the host read them back as 32-bit words: low half first, then high half.
- Sits between the processing block output and the host register/read interface.

Parameters:
- DATA_W, 64, stream sample width; fixed to 2x RD_W.
- RD_W, 32, host read word width.
- DEPTH_LOG2, 10, log2 of buffer depth in samples (default 1024).

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- arm  in  1  one-cycle pulse; starts a new capture
- n_samples  in  32  capture length; latched on arm
- data_in  in  64  processed sample
- data_in_valid  in  1  sample qualifier; no backpressure
- rd_req  in  1  host read request, one word per cycle
- rd_data  out  32  read data
- rd_data_valid  out  1  read data qualifier
- busy  out  1  high in CAPTURE
- capture_done  out  1  high in DONE
- samples_stored  out  DEPTH_LOG2+1  samples written this capture
- underrun  out  1  sticky: a read went past the last stored sample
- rd_err  out  1  one-cycle pulse: rd_req issued outside DONE

Behaviour:
- Interface: reset reset_n, synchronous, active-low; clock clk.
- Reset: FSM to IDLE, all pointers 0, and every output 0 (rd_data, rd_data_valid, busy, capture_done, samples_stored, underrun, rd_err).
- Reset mid-capture or mid-read: abort immediately; in-flight reads produce no rd_data_valid.
- FSM states are IDLE, CAPTURE and DONE.
- arm from any state:
  - Latches target = min(n_samples, 2^DEPTH_LOG2).
  - Clears write pointer, read pointer, half select, samples_stored and underrun.
  - Next state is CAPTURE; if target == 0, next state is DONE instead.
  - arm also flushes the read pipeline: reads in flight are dropped, with no rd_data_valid.
- arm has priority over a data_in_valid in the same cycle. That sample is not stored; capture begins on the following cycle.
- CAPTURE:
  - Each data_in_valid writes data_in to RAM[wr_ptr] and increments wr_ptr and samples_stored.
  - The write that makes samples_stored == target moves the FSM to DONE on the next clock edge.
  - Valid samples received in DONE or IDLE are discarded.
- DONE, per rd_req:
  - Word returned is RAM[rd_ptr][31:0] when half = 0, RAM[rd_ptr][63:32] when half = 1.
  - half toggles on every read; rd_ptr increments after the high half is read.
- Read latency is fixed at 2 cycles: rd_req at cycle N gives rd_data_valid at N+2.
  - One cycle is for the registered RAM address, one for the registered output.
  - Back-to-back rd_req every cycle is supported at full throughput.
- Reading past the end (rd_ptr >= samples_stored): return rd_data = 0 with rd_data_valid = 1, set underrun, and hold rd_ptr.
- rd_req in IDLE or CAPTURE: rd_err pulses one cycle later, with no rd_data_valid.
- rd_data keeps its last value when rd_data_valid = 0.
- RAM is simple dual-port with a registered read. Read and write never target the same sample, because reads are only allowed in DONE.

Optional Feature:
- Macro: CAPTURE_READ_WRAP_EN.
- When defined: after the high half of sample samples_stored-1 is read, rd_ptr wraps to 0 and half to 0. Reads never underrun and underrun stays 0, except with samples_stored == 0, which behaves as without the macro.
- When undefined: past-end behaviour is as in Behaviour (zeros returned, underrun set).

Test Plan:
- Basic capture/readback: arm with n_samples = 4; feed 64'h00000001_AAAA0000 + i for i = 0..3 on consecutive cycles. capture_done rises; samples_stored = 4; 8 back-to-back rd_req return AAAA0000, 00000001, AAAA0001, 00000001, ..., each valid 2 cycles after its request.
- Gapped input and clamp: DEPTH_LOG2 = 4, n_samples = 100, data_in_valid every 3rd cycle. busy stays high for exactly 16 stored samples, then DONE with samples_stored = 16; extra valids are ignored.
- Underrun: after capturing 2 samples, issue 6 reads. The first 4 return data; the last 2 return 0 with rd_data_valid = 1 and underrun = 1. With CAPTURE_READ_WRAP_EN, reads 5-6 return sample 0 low/high and underrun stays 0.
- Access outside DONE: rd_req during CAPTURE gives an rd_err pulse, no rd_data_valid, and the capture is unaffected. arm together with data_in_valid: that sample is absent from the buffer.
- Re-arm mid-read: issue rd_req on 2 cycles, then arm on the next. No rd_data_valid appears for those reads; pointers and underrun are cleared; the new capture of 3 samples reads back correctly. n_samples = 0 goes straight to capture_done with samples_stored = 0.
- Reset mid-capture: deassert reset_n for 1 cycle after 5 of 8 samples. All outputs are 0 and the FSM is in IDLE; a new capture of 8 then completes normally.
